mem_arbiter: RTL and testbench

//  Shares one 256-bit block memory port between the instruction cache (I) and
//  the data cache (D). Sits between both cache mem_* interfaces and main memory.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-transaction-at-a-time arbiter sharing a block memory port between I- and D-cache
// Optional round-robin tie-break: MEM_ARB_RR_EN (fixed D priority when undefined).
module mem_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_i,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   req_i, req_d, pick_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // rr_last: 0 = I won the last grant, 1 = D won it
    logic rr_last;

    assign pick_d = req_d & (~req_i | ~rr_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b0;
        end else if (state == IDLE && state_nxt != IDLE) begin
            rr_last <= (state_nxt == GNT_D);
        end
    end
`else
    assign pick_d = req_d;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = GNT_D;
                end else if (req_i) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request is captured only on the grant edge; a simultaneous read+write counts as a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (state_nxt == GNT_D) begin
                mem_read  <= d_read & ~d_write;
                mem_write <= d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (state_nxt == GNT_I) begin
                mem_read  <= i_read & ~i_write;
                mem_write <= i_write;
                mem_addr  <= i_addr;
                mem_wdata <= i_wdata;
            end
        end else if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    assign grant_i = (state == GNT_I);
    assign grant_d = (state == GNT_D);
    assign i_ready = grant_i & mem_ready;
    assign d_ready = grant_d & mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic              i_ready, d_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ready;
    logic              grant_i, grant_d;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        mem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1;
        step();
    endtask

    task automatic serve();
        mem_ready = 1;
        step();
        mem_ready = 0;
    endtask

    typedef struct {
        bit ir, iw, dr, dw;
        bit eg_i, eg_d, e_rd, e_wr;
    } vec_t;

    vec_t tbl[7];

    // Random-run reference: owner 0 = none, 1 = I, 2 = D
    int                owner;
    bit                rr_d;
    bit                i_pend, d_pend;
    bit                e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    initial begin
        logic [DATA_W-1:0] pat;
        logic [ADDR_W-1:0] ta, tb_a;
        int                win;

        idle_inputs();
        i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0; mem_rdata = 0;
        rst_n = 0;
        #1;
        chk("reset_grant_i", grant_i, 0);
        chk("reset_grant_d", grant_d, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        do_reset();

        // 1: reset in the middle of a D grant
        d_read = 1; d_addr = 27'h0000777;
        step();
        chk("t1_grant_d", grant_d, 1);
        chk("t1_mem_read", mem_read, 1);
        rst_n = 0;
        #1;
        chk("t1_rst_mem_read", mem_read, 0);
        chk("t1_rst_grant_d", grant_d, 0);
        chk("t1_rst_mem_addr", mem_addr, 0);
        d_read = 0;
        step();
        rst_n = 1;
        step();
        chk("t1_post_grant", {grant_i, grant_d, mem_read, mem_write}, 0);

        // 2: single I read with 4-cycle memory latency
        i_read = 1; i_addr = 27'h12345;
        step();
        chk("t2_mem_read", mem_read, 1);
        chk("t2_mem_addr", mem_addr, 27'h12345);
        chk("t2_grant_i", grant_i, 1);
        repeat (3) begin
            step();
            chk("t2_wait_i_ready", i_ready, 0);
        end
        pat = {8{32'hC0DE_1234}};
        mem_rdata = pat; mem_ready = 1;
        #1;
        chk("t2_i_ready", i_ready, 1);
        chk("t2_i_rdata", i_rdata, pat);
        chk("t2_d_ready", d_ready, 0);
        step();
        mem_ready = 0; i_read = 0;
        #1;
        chk("t2_done_i_ready", i_ready, 0);
        chk("t2_done_mem_read", mem_read, 0);
        chk("t2_done_grant_i", grant_i, 0);
        step();

        // 3: D write-back then allocate, one idle cycle between
        ta = 27'h3001234; tb_a = 27'h0456789; pat = {8{32'hDEAD_BEEF}};
        d_write = 1; d_addr = ta; d_wdata = pat;
        step();
        chk("t3_mem_write", mem_write, 1);
        chk("t3_mem_read", mem_read, 0);
        chk("t3_mem_wdata", mem_wdata, pat);
        chk("t3_mem_addr", mem_addr, ta);
        step();
        mem_ready = 1;
        #1;
        chk("t3_d_ready", d_ready, 1);
        step();
        mem_ready = 0; d_write = 0; d_read = 1; d_addr = tb_a;
        #1;
        chk("t3_gap_mem_read", mem_read, 0);
        chk("t3_gap_grant_d", grant_d, 0);
        step();
        chk("t3_alloc_mem_read", mem_read, 1);
        chk("t3_alloc_mem_addr", mem_addr, tb_a);
        serve();
        d_read = 0;
        step();

        // 4/5: ties (fresh reset so round-robin history starts at I)
        do_reset();
        i_addr = 27'h1111111; d_addr = 27'h2222222;
        i_read = 1; d_read = 1;
        step();
        chk("tie1_grant_d", grant_d, 1);
        chk("tie1_mem_addr", mem_addr, 27'h2222222);
        serve();
        d_read = 0;
        step();
        chk("tie1_then_grant_i", grant_i, 1);
        chk("tie1_then_mem_addr", mem_addr, 27'h1111111);
        serve();
        i_read = 0;
        step();
        i_read = 1; d_read = 1;
        step();
        chk("tie2_grant_d", grant_d, 1);
        serve();
        i_read = 0; d_read = 0;
        step();
        i_read = 1; d_read = 1;
        step();
`ifdef MEM_ARB_RR_EN
        chk("tie3_grant_i", grant_i, 1);
`else
        chk("tie3_grant_d", grant_d, 1);
`endif
        serve();
        i_read = 0; d_read = 0;
        step();
        i_read = 1; d_read = 1;
        step();
        chk("tie4_grant_d", grant_d, 1);
        serve();
        i_read = 0; d_read = 0;
        step();

        // 6: read+write treated as write; stray mem_ready in IDLE is ignored
        d_read = 1; d_write = 1;
        step();
        chk("t6_mem_write", mem_write, 1);
        chk("t6_mem_read", mem_read, 0);
        serve();
        d_read = 0; d_write = 0;
        step();
        mem_ready = 1;
        #1;
        chk("t6_idle_d_ready", d_ready, 0);
        chk("t6_idle_i_ready", i_ready, 0);
        step();
        mem_ready = 0;
        chk("t6_idle_grants", {grant_i, grant_d, mem_write, mem_read}, 0);

        // Table: single-requester patterns from IDLE
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 1, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 0, 1, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 0, 1, 0, 0, 1};
        tbl[4] = '{0, 0, 1, 0, 0, 1, 1, 0};
        tbl[5] = '{0, 0, 0, 1, 0, 1, 0, 1};
        tbl[6] = '{0, 0, 1, 1, 0, 1, 0, 1};
        for (int k = 0; k < 7; k++) begin
            i_addr = 27'h2AAAAAA; d_addr = 27'h5555555;
            i_wdata = {8{32'hA5A5_0000}}; d_wdata = {8{32'h5A5A_FFFF}};
            i_read = tbl[k].ir; i_write = tbl[k].iw;
            d_read = tbl[k].dr; d_write = tbl[k].dw;
            step();
            chk($sformatf("vec%0d_grant_i", k), grant_i, tbl[k].eg_i);
            chk($sformatf("vec%0d_grant_d", k), grant_d, tbl[k].eg_d);
            chk($sformatf("vec%0d_mem_read", k), mem_read, tbl[k].e_rd);
            chk($sformatf("vec%0d_mem_write", k), mem_write, tbl[k].e_wr);
            if (tbl[k].eg_d) begin
                chk($sformatf("vec%0d_addr", k), mem_addr, 27'h5555555);
                chk($sformatf("vec%0d_wdata", k), mem_wdata, {8{32'h5A5A_FFFF}});
            end else if (tbl[k].eg_i) begin
                chk($sformatf("vec%0d_addr", k), mem_addr, 27'h2AAAAAA);
                chk($sformatf("vec%0d_wdata", k), mem_wdata, {8{32'hA5A5_0000}});
            end
            mem_ready = 1;
            #1;
            chk($sformatf("vec%0d_i_ready", k), i_ready, tbl[k].eg_i);
            chk($sformatf("vec%0d_d_ready", k), d_ready, tbl[k].eg_d);
            step();
            idle_inputs();
            chk($sformatf("vec%0d_released", k), {grant_i, grant_d, mem_read, mem_write}, 0);
            step();
        end

        // Randomized run against a transaction-level reference
        do_reset();
        owner = 0; rr_d = 0; i_pend = 0; d_pend = 0;
        e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                case ($urandom_range(0, 2))
                    0: begin i_read = 1; i_write = 0; end
                    1: begin i_read = 0; i_write = 1; end
                    default: begin i_read = 1; i_write = 1; end
                endcase
            end else if (!i_pend) begin
                i_read = 0; i_write = 0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                case ($urandom_range(0, 2))
                    0: begin d_read = 1; d_write = 0; end
                    1: begin d_read = 0; d_write = 1; end
                    default: begin d_read = 1; d_write = 1; end
                endcase
            end else if (!d_pend) begin
                d_read = 0; d_write = 0;
            end
            i_addr = ADDR_W'($urandom); d_addr = ADDR_W'($urandom);
            i_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem_ready = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);

            @(negedge clk);
            chk("rnd_grant_i", grant_i, owner == 1);
            chk("rnd_grant_d", grant_d, owner == 2);
            chk("rnd_mem_read", mem_read, e_rd);
            chk("rnd_mem_write", mem_write, e_wr);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_wdata);
            chk("rnd_i_ready", i_ready, (owner == 1) && mem_ready);
            chk("rnd_d_ready", d_ready, (owner == 2) && mem_ready);
            chk("rnd_i_rdata", i_rdata, mem_rdata);
            chk("rnd_d_rdata", d_rdata, mem_rdata);

            if (owner != 0) begin
                if (mem_ready) begin
                    if (owner == 1) i_pend = 0;
                    else d_pend = 0;
                    owner = 0; e_rd = 0; e_wr = 0;
                end
            end else begin
                win = 0;
                if ((i_read | i_write) && (d_read | d_write)) begin
`ifdef MEM_ARB_RR_EN
                    win = rr_d ? 1 : 2;
`else
                    win = 2;
`endif
                end else if (i_read | i_write) begin
                    win = 1;
                end else if (d_read | d_write) begin
                    win = 2;
                end
                if (win == 1) begin
                    owner = 1; rr_d = 0;
                    e_wr = i_write; e_rd = i_read & ~i_write;
                    e_addr = i_addr; e_wdata = i_wdata;
                end else if (win == 2) begin
                    owner = 2; rr_d = 1;
                    e_wr = d_write; e_rd = d_read & ~d_write;
                    e_addr = d_addr; e_wdata = d_wdata;
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
